// File: rtl/pattern_scan_seq.sv
// Sequential bit-pattern locator: walks a latched word one window per clock from the LSB,
// reporting the lowest match position and, in count-all mode, the number of matches.
module pattern_scan_seq #(
    parameter int                  WORD_SIZE  = 16,
    parameter int                  PAT_SIZE   = 3,
    parameter logic [PAT_SIZE-1:0] PATTERN    = 3'b101,
    parameter int                  INDEX_SIZE = 5,
    parameter int                  COUNT_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_SIZE-1:0]  word_in,
    input  logic                  mode,
    input  logic                  overlap,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [INDEX_SIZE-1:0] index_out,
    output logic [COUNT_SIZE-1:0] match_count
);

    // One extra bit so the advanced position can exceed the last legal window without wrapping.
    localparam int POS_W = $clog2(WORD_SIZE + 1) + 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(WORD_SIZE - PAT_SIZE);
    localparam logic [POS_W-1:0] PAT_STEP = POS_W'(PAT_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_SIZE-1:0]  word_q, word_d;
    logic                  mode_q, mode_d;
    logic                  overlap_q, overlap_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic                  found_q, found_d;
    logic [INDEX_SIZE-1:0] index_q, index_d;
    logic [COUNT_SIZE-1:0] count_q, count_d;

    logic [WORD_SIZE-1:0]  shifted;
    logic [PAT_SIZE-1:0]   window;
    logic [POS_W-1:0]      posNext;

    assign shifted = word_q >> pos_q;
    assign window  = shifted[PAT_SIZE-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            mode_q    <= 1'b0;
            overlap_q <= 1'b0;
            pos_q     <= '0;
            found_q   <= 1'b0;
            index_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            mode_q    <= mode_d;
            overlap_q <= overlap_d;
            pos_q     <= pos_d;
            found_q   <= found_d;
            index_q   <= index_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        mode_d    = mode_q;
        overlap_d = overlap_q;
        pos_d     = pos_q;
        found_d   = found_q;
        index_d   = index_q;
        count_d   = count_q;
        posNext   = pos_q + POS_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d    = word_in;
                    mode_d    = mode;
                    overlap_d = overlap;
                    pos_d     = '0;
                    found_d   = 1'b0;
                    index_d   = '0;
                    count_d   = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                // No remaining set bits means a nonzero pattern can never match again.
                if ((PATTERN != '0) && (shifted == '0)) begin
                    state_d = DONE;
                end else begin
                    if (window == PATTERN) begin
                        if (!found_q) begin
                            found_d = 1'b1;
                            index_d = INDEX_SIZE'(pos_q);
                        end
                        if (count_q != '1) begin
                            count_d = count_q + COUNT_SIZE'(1);
                        end
                        posNext = pos_q + (overlap_q ? POS_W'(1) : PAT_STEP);
                        if (!mode_q) begin
                            state_d = DONE;
                        end
                    end
                    pos_d = posNext;
                    if (posNext > LAST_POS) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == SCAN);
    assign done        = (state_q == DONE);
    assign found       = found_q;
    assign index_out   = index_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_pattern_scan_seq.sv
// Directed bench for pattern_scan_seq with default parameters (16-bit word, pattern 101):
// table of scans with hand-computed results plus sequences for ignored starts and resets.
module tb_pattern_scan_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] word_in;
    logic        mode;
    logic        overlap;
    logic        busy;
    logic        done;
    logic        found;
    logic [4:0]  index_out;
    logic [4:0]  match_count;

    int compares;
    int miscompares;

    typedef struct {
        string       name;
        logic [15:0] word;
        logic        mode;
        logic        overlap;
        int          expFound;
        int          expIndex;
        int          expCount;
        int          expLatency;
    } vec_t;

    vec_t vecs[12];

    pattern_scan_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_in    (word_in),
        .mode       (mode),
        .overlap    (overlap),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .index_out  (index_out),
        .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compares++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches a scan and returns the cycle offset of done relative to the start edge (E+1+n).
    task automatic applyStimulus(input logic [15:0] w, input logic m, input logic o,
                                 output int latency);
        int edges;
        word_in = w;
        mode    = m;
        overlap = o;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        checkOutput("busy after start", int'(busy), 1);
        edges   = 0;
        latency = -1;
        while (edges < 40) begin
            tick();
            edges++;
            if (done) begin
                latency = edges + 1;
                break;
            end
        end
        if (latency < 0) begin
            checkOutput("done timeout", 0, 1);
        end else begin
            checkOutput("busy low during done", int'(busy), 0);
        end
    endtask

    initial begin
        int lat;
        compares    = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        word_in     = '0;
        mode        = 1'b0;
        overlap     = 1'b0;

        vecs[0]  = '{"first match p0",        16'h0005, 1'b0, 1'b0, 1,  0, 1,  2};
        vecs[1]  = '{"count overlap 0015",    16'h0015, 1'b1, 1'b1, 1,  0, 2,  7};
        vecs[2]  = '{"count nonoverlap 0015", 16'h0015, 1'b1, 1'b0, 1,  0, 1,  5};
        vecs[3]  = '{"match at top A000",     16'hA000, 1'b0, 1'b0, 1, 13, 1, 15};
        vecs[4]  = '{"zero word mode0",       16'h0000, 1'b0, 1'b0, 0,  0, 0,  2};
        vecs[5]  = '{"zero word mode1",       16'h0000, 1'b1, 1'b1, 0,  0, 0,  2};
        vecs[6]  = '{"full scan FFFF",        16'hFFFF, 1'b1, 1'b1, 0,  0, 0, 15};
        vecs[7]  = '{"last window count",     16'hA000, 1'b1, 1'b1, 1, 13, 1, 15};
        vecs[8]  = '{"5555 overlap",          16'h5555, 1'b1, 1'b1, 1,  0, 7, 15};
        vecs[9]  = '{"5555 nonoverlap",       16'h5555, 1'b1, 1'b0, 1,  0, 4,  8};
        vecs[10] = '{"5555 mode0",            16'h5555, 1'b0, 1'b0, 1,  0, 1,  2};
        vecs[11] = '{"match at p3",           16'h0028, 1'b0, 1'b0, 1,  3, 1,  5};

        tick();
        tick();
        checkOutput("reset busy",  int'(busy), 0);
        checkOutput("reset done",  int'(done), 0);
        checkOutput("reset found", int'(found), 0);
        checkOutput("reset index", int'(index_out), 0);
        checkOutput("reset count", int'(match_count), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].word, vecs[i].mode, vecs[i].overlap, lat);
            checkOutput({vecs[i].name, " latency"}, lat, vecs[i].expLatency);
            checkOutput({vecs[i].name, " found"}, int'(found), vecs[i].expFound);
            checkOutput({vecs[i].name, " index"}, int'(index_out), vecs[i].expIndex);
            checkOutput({vecs[i].name, " count"}, int'(match_count), vecs[i].expCount);
            tick();
            checkOutput({vecs[i].name, " done one cycle"}, int'(done), 0);
            tick();
        end

        // Results hold in IDLE while start stays low.
        checkOutput("hold found", int'(found), 1);
        checkOutput("hold index", int'(index_out), 3);

        // Second start and a changing word_in mid-scan must not disturb the latched scan.
        word_in = 16'hA000;
        mode    = 1'b0;
        overlap = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        word_in = 16'h0005;
        mode    = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        lat     = -1;
        for (int e = 0; e < 40; e++) begin
            if (done) begin
                lat = e + 4;
                break;
            end
            tick();
        end
        checkOutput("ignored start latency", lat, 15);
        checkOutput("ignored start index", int'(index_out), 13);
        checkOutput("ignored start count", int'(match_count), 1);
        tick();
        tick();

        // Reset mid-scan aborts without a done pulse.
        word_in = 16'hA000;
        start   = 1'b1;
        mode    = 1'b0;
        tick();
        start   = 1'b0;
        tick();
        tick();
        checkOutput("busy before abort", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        checkOutput("abort busy",  int'(busy), 0);
        checkOutput("abort done",  int'(done), 0);
        checkOutput("abort found", int'(found), 0);
        checkOutput("abort index", int'(index_out), 0);
        checkOutput("abort count", int'(match_count), 0);
        rst_n = 1'b1;
        begin
            int sawDone;
            sawDone = 0;
            for (int e = 0; e < 20; e++) begin
                tick();
                if (done || busy) sawDone = 1;
            end
            checkOutput("no activity after abort", sawDone, 0);
        end

        applyStimulus(16'h0028, 1'b0, 1'b0, lat);
        checkOutput("post-reset latency", lat, 5);
        checkOutput("post-reset index", int'(index_out), 3);
        checkOutput("post-reset found", int'(found), 1);
        tick();
        tick();

        // Reset wins over a simultaneous start.
        word_in = 16'h0005;
        start   = 1'b1;
        rst_n   = 1'b0;
        tick();
        checkOutput("reset vs start busy", int'(busy), 0);
        checkOutput("reset vs start found", int'(found), 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        checkOutput("reset vs start idle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", compares, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_scan_seq.md
Name: pattern_scan_seq

Overview:
- Clocked, parametrised bit-pattern locator. It scans a latched data word one bit position per clock, starting from the LSB.
- Generalises the fixed 3-bit "101" comma locator in three ways: configurable word width, configurable pattern and pattern width, and a count-all mode with overlapping or non-overlapping matches.
- Uses a start/busy/done handshake.
- Sits between a word source (deserialiser or register) and framing/alignment logic that consumes the index and match count.

Parameters:
- WORD_SIZE, 16: width of the scanned word.
- PAT_SIZE, 3: pattern width in bits; legal range 1..WORD_SIZE.
- PATTERN, 3'b101: pattern value, PAT_SIZE bits wide.
- INDEX_SIZE, 5: width of index_out; must satisfy 2**INDEX_SIZE > WORD_SIZE-PAT_SIZE.
- COUNT_SIZE, 5: width of match_count.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous active-low reset. Reset is synchronous, active-low, on the single clock clk.
- start, input, 1: launch a scan. Sampled only in IDLE.
- word_in, input, WORD_SIZE: word to scan. Latched on the accepted start edge.
- mode, input, 1: 0 = stop at first match; 1 = count all matches. Latched with start.
- overlap, input, 1: in mode 1, 1 = overlapping matches count; 0 = resume after the matched window. Latched with start.
- busy, output, 1: scan in progress.
- done, output, 1: one-cycle pulse; results are valid.
- found, output, 1: at least one match occurred.
- index_out, output, INDEX_SIZE: bit position p of the lowest match, where word[p+PAT_SIZE-1:p] == PATTERN.
- match_count, output, COUNT_SIZE: number of matches counted.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, found=0, index_out=0, match_count=0; internal position pos=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge E: latch word_in, mode and overlap; clear found, index_out and match_count; pos=0; go to SCAN (busy=1 from E).
  - start=0: stay in IDLE; outputs hold previous results.
- SCAN: one window is evaluated per edge, at pos.
  - Early exit: if PATTERN!=0 and (latched_word >> pos)==0, go to DONE with no match recorded at this edge.
  - Match, first one: found=1, index_out=pos.
  - Match, mode 0: go to DONE.
  - Match, mode 1: match_count increments, saturating at all-ones. pos advances by 1 if overlap=1, by PAT_SIZE if overlap=0.
  - No match: pos advances by 1.
  - End of word: if the next pos > WORD_SIZE-PAT_SIZE, go to DONE after this evaluation.
  - In mode 0, match_count equals found (0 or 1).
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. found, index_out and match_count hold until the next accepted start.
- Latency:
  - done is high in cycle E+1+n, where n = number of SCAN evaluations.
  - Mode 0 with first match at p (no early exit): n=p+1.
  - Full scan with no early exit: n = WORD_SIZE-PAT_SIZE+1.
- Boundary cases:
  - start while busy or in DONE: ignored; the latched word is unaffected.
  - word_in changing mid-scan: no effect.
  - PATTERN==0: early exit disabled.
  - PAT_SIZE==WORD_SIZE: single evaluation.
  - A match in the last window is still recorded.
  - rst_n=0 mid-scan: abort to IDLE with reset values; no done pulse.
  - start and rst_n=0 in the same cycle: reset wins.

Test Plan:
- Reset, then mode=0, word_in=16'h0005, start at E -> done in cycle E+2; found=1, index_out=0, match_count=1.
- mode=1, overlap=1, word_in=16'h0015 -> matches at p=0 and p=2; early exit at pos=5; found=1, index_out=0, match_count=2; done in cycle E+7.
- Same word, overlap=0 -> evaluations at p=0, 3, 4, 5 (early exit at 5); match_count=1, index_out=0.
- mode=0, word_in=16'hA000 (pattern at bits 15:13) -> done in cycle E+15; index_out=13, found=1.
- word_in=16'h0000 -> done in cycle E+2; found=0, index_out=0, match_count=0.
- Start a scan, pulse start again during SCAN, then drive rst_n=0 mid-scan -> second start ignored; reset drives busy=0 and all outputs to 0 with no done pulse. A new start after release gives the correct result.
